// File: rtl/parity_fifo_pkg.sv
// Shared types and helpers for the parity-screening FIFO.
// Contents: parity_mode_e, pointer/count width helpers, parity_ok().
package parity_fifo_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_mode_e;

    // Widest word parity_ok() can screen; narrower words are zero-extended,
    // which leaves their parity unchanged.
    localparam int unsigned MAX_DATA_W = 256;

    // Address width for an arbitrary (non power-of-two) depth.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Occupancy width: must also represent the value "depth" itself.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic parity_ok(input logic [MAX_DATA_W-1:0] data,
                                       input parity_mode_e          mode);
        case (mode)
            PAR_EVEN: return ~(^data);
            PAR_ODD:  return ^data;
            default:  return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array for parity_fifo_v2: synchronous write, asynchronous read.
// Ports: clk, we/waddr/wdata (write port), raddr/rdata (read port).
module fifo_ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/parity_fifo_v2.sv
// First-word-fall-through FIFO that screens parity at the write port.
// Ports:
//   clk, rst (sync, active-high), flush_i (sync clear, counters kept)
//   data_i/valid_i/grant_o      : producer side handshake
//   data_o/valid_o/grant_i      : consumer side handshake
//   count_o, almost_full_o, almost_empty_o : occupancy telemetry
//   err_o (1-cycle drop pulse), drop_cnt_o (saturating drop count)
module parity_fifo_v2
    import parity_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned PARITY_MODE = 1,
    parameter int unsigned AF_THRESH   = FIFO_DEPTH - 1,
    parameter int unsigned AE_THRESH   = 1,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush_i,
    input  logic [DATA_WIDTH-1:0]              data_i,
    input  logic                               valid_i,
    output logic                               grant_o,
    output logic [DATA_WIDTH-1:0]              data_o,
    output logic                               valid_o,
    input  logic                               grant_i,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    count_o,
    output logic                               almost_full_o,
    output logic                               almost_empty_o,
    output logic                               err_o,
    output logic [CNT_WIDTH-1:0]               drop_cnt_o
);

    localparam int unsigned  PTR_W = ptr_w(FIFO_DEPTH);
    localparam int unsigned  CNT_W = cnt_w(FIFO_DEPTH);
    localparam parity_mode_e MODE  = parity_mode_e'(PARITY_MODE[1:0]);

    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [CNT_WIDTH-1:0] drop_cnt;
    logic                 err_q;

    logic full;
    logic par_ok;
    logic wr_fire;
    logic wr_good;
    logic wr_bad;
    logic rd_fire;

    // Pointer increment with wrap at an arbitrary depth.
    function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake qualification; no pass-through when full, nothing taken during flush.
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign grant_o = !full && !flush_i;
    assign valid_o = (count != '0);
    assign par_ok  = parity_ok(MAX_DATA_W'(data_i), MODE);
    assign wr_fire = valid_i && grant_o;
    assign wr_good = wr_fire && par_ok;
    assign wr_bad  = wr_fire && !par_ok;
    assign rd_fire = valid_o && grant_i && !flush_i;

    // Pointers, occupancy and drop telemetry; rst beats flush beats handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
            err_q    <= 1'b0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= wr_bad;
            if (wr_good) begin
                wr_ptr <= inc_ptr(wr_ptr);
            end
            if (rd_fire) begin
                rd_ptr <= inc_ptr(rd_ptr);
            end
            if (wr_good && !rd_fire) begin
                count <= count + CNT_W'(1);
            end else if (!wr_good && rd_fire) begin
                count <= count - CNT_W'(1);
            end
            if (wr_bad && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + CNT_WIDTH'(1);
            end
        end
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .ADDR_WIDTH (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_good && !rst),
        .waddr (wr_ptr),
        .wdata (data_i),
        .raddr (rd_ptr),
        .rdata (data_o)
    );

    assign count_o        = count;
    assign almost_full_o  = (count >= CNT_W'(AF_THRESH));
    assign almost_empty_o = (count <= CNT_W'(AE_THRESH));
    assign err_o          = err_q;
    assign drop_cnt_o     = drop_cnt;

    // Occupancy must stay within [0, FIFO_DEPTH].
    a_count_max: assert property (@(posedge clk) disable iff (rst)
        count <= CNT_W'(FIFO_DEPTH));
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(wr_good && full));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(rd_fire && (count == '0)));

endmodule
